// File: rtl/state_seq.sv
// State register that closes the loop around an external next-state lookup table.
// Optional one-hot checking of the returned value is enabled by defining ONEHOT_CHECK_EN.
module state_seq #(
    parameter int DWELL = 4,
    parameter int ERRW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            step_i,
    input  logic            hold_i,
    input  logic            mode_i,
    input  logic            clr_i,
    input  logic [4:0]      nxt_i,
    output logic [4:0]      state_o,
    output logic            sel_o,
    output logic            busy_o,
    output logic            ovf_o,
    output logic            err_o,
    output logic [ERRW-1:0] err_cnt_o
);

    localparam logic [4:0] STATE_RST = 5'b00001;
    localparam logic [3:0] DONE_CNT  = 4'(DWELL - 1);

    logic [4:0] r_state;
    logic       r_sel;
    logic       r_pending;
    logic [3:0] r_cnt;
    logic       r_ovf;

    logic       w_done;
    logic       w_load;
    logic       w_drop;
    logic       w_err;
    logic [4:0] w_state_d;
    logic       w_pending_d;
    logic [3:0] w_cnt_d;

    // A request is served once the dwell has expired; a second request may
    // queue behind it, and a third one while one is queued is dropped.
    always_comb begin
        w_done      = (r_cnt == DONE_CNT);
        w_load      = (step_i | r_pending) & w_done & ~hold_i;
        w_drop      = step_i & r_pending & ~w_load;

        w_pending_d = r_pending;
        if (w_load) begin
            w_pending_d = step_i & r_pending;
        end else if (step_i) begin
            w_pending_d = 1'b1;
        end

        w_cnt_d = r_cnt;
        if (w_load) begin
            w_cnt_d = '0;
        end else if (!hold_i && !w_done) begin
            w_cnt_d = r_cnt + 4'd1;
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic            w_onehot;
    logic            r_err;
    logic [ERRW-1:0] r_err_cnt;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    always_comb begin
        w_onehot  = (nxt_i != 5'd0) && ((nxt_i & (nxt_i - 5'd1)) == 5'd0);
        w_err     = w_load & ~w_onehot;
        w_state_d = w_err ? STATE_RST : nxt_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_err;
            if (w_err) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end else if (clr_i) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
`else
    always_comb begin
        w_err     = 1'b0;
        w_state_d = nxt_i;
    end

    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; the reset branch is asynchronous and applies at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= STATE_RST;
            r_sel     <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= DONE_CNT;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_pending_d;
            r_cnt     <= w_cnt_d;
            if (w_load) begin
                r_state <= w_state_d;
            end
            if (!hold_i) begin
                r_sel <= mode_i;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_i) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign state_o = r_state;
    assign sel_o   = r_sel;
    assign busy_o  = r_pending | ~w_done;
    assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_state_seq.sv
// Self-checking bench for state_seq: a per-edge behavioural model plus directed
// vectors with literal expectations; a second instance exercises DWELL=1.
module tb_state_seq;

    localparam int DWELL = 4;
    localparam int ERRW  = 4;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b1;
    logic            step_i = 1'b0;
    logic            hold_i = 1'b0;
    logic            mode_i = 1'b0;
    logic            clr_i  = 1'b0;
    logic [4:0]      nxt_i  = 5'd0;

    logic [4:0]      state_o;
    logic            sel_o, busy_o, ovf_o, err_o;
    logic [ERRW-1:0] err_cnt_o;

    logic [4:0]      d1_state_o;
    logic            d1_sel_o, d1_busy_o, d1_ovf_o, d1_err_o;
    logic [ERRW-1:0] d1_err_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    state_seq #(.DWELL(DWELL), .ERRW(ERRW)) dut (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .hold_i(hold_i),
        .mode_i(mode_i), .clr_i(clr_i), .nxt_i(nxt_i),
        .state_o(state_o), .sel_o(sel_o), .busy_o(busy_o), .ovf_o(ovf_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    state_seq #(.DWELL(1), .ERRW(ERRW)) dut1 (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .hold_i(hold_i),
        .mode_i(mode_i), .clr_i(clr_i), .nxt_i(nxt_i),
        .state_o(d1_state_o), .sel_o(d1_sel_o), .busy_o(d1_busy_o), .ovf_o(d1_ovf_o),
        .err_o(d1_err_o), .err_cnt_o(d1_err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Behavioural model: m_elapsed counts non-hold edges since the last load.
    logic [4:0] m_state;
    logic       m_sel, m_pend, m_ovf, m_err;
    int         m_elapsed, m_errcnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state   = 5'b00001;
            m_sel     = 1'b0;
            m_pend    = 1'b0;
            m_elapsed = DWELL - 1;
            m_ovf     = 1'b0;
            m_err     = 1'b0;
            m_errcnt  = 0;
        end else begin
            bit ready, ld, drop, bad;
            ready = (m_elapsed >= DWELL - 1);
            ld    = (step_i || m_pend) && ready && !hold_i;
            drop  = step_i && m_pend && !ld;
`ifdef ONEHOT_CHECK_EN
            bad   = ld && ($countones(nxt_i) != 1);
`else
            bad   = 1'b0;
`endif
            if (ld) m_state = bad ? 5'b00001 : nxt_i;
            if (ld) m_pend = step_i && m_pend;
            else if (step_i) m_pend = 1'b1;
            if (ld) m_elapsed = 0;
            else if (!hold_i) m_elapsed = m_elapsed + 1;
            if (!hold_i) m_sel = mode_i;
            if (drop) m_ovf = 1'b1;
            else if (clr_i) m_ovf = 1'b0;
            m_err = bad;
            if (bad) m_errcnt = (m_errcnt < ERR_MAX) ? m_errcnt + 1 : ERR_MAX;
            else if (clr_i) m_errcnt = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            check("m_state",  state_o,   m_state);
            check("m_sel",    sel_o,     m_sel);
            check("m_busy",   busy_o,    m_pend || (m_elapsed < DWELL - 1));
            check("m_ovf",    ovf_o,     m_ovf);
            check("m_err",    err_o,     m_err);
            check("m_errcnt", err_cnt_o, m_errcnt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", state_o, 5'b00001);
        check("rst_sel", sel_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_ovf", ovf_o, 1'b0);
        check("rst_errcnt", err_cnt_o, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_state", state_o, 5'b00001);

        // Latency: load on the step edge, busy for DWELL-1 further edges
        step_i = 1'b1; nxt_i = 5'b01000;
        tick();
        check("lat_state", state_o, 5'b01000);
        check("lat_busy_k", busy_o, 1'b1);
        step_i = 1'b0; nxt_i = 5'b00000;
        tick(); tick();
        check("lat_busy_k2", busy_o, 1'b1);
        tick();
        check("lat_busy_k3", busy_o, 1'b0);

        // Pending and overflow
        step_i = 1'b1; nxt_i = 5'b00010;
        tick();
        check("pend_load", state_o, 5'b00010);
        nxt_i = 5'b10000;
        tick();
        check("pend_ovf0", ovf_o, 1'b0);
        tick();
        check("pend_ovf1", ovf_o, 1'b1);
        step_i = 1'b0;
        tick();
        check("pend_wait", state_o, 5'b00010);
        tick();
        check("pend_expiry", state_o, 5'b10000);
        clr_i = 1'b1;
        tick();
        check("clr_ovf", ovf_o, 1'b0);
        clr_i = 1'b0;
        tick(); tick(); tick();

        // Hold with a request pending
        step_i = 1'b1; nxt_i = 5'b00100;
        tick();
        tick();
        step_i = 1'b0; hold_i = 1'b1; mode_i = 1'b1; nxt_i = 5'b01000;
        for (int i = 0; i < 5; i++) begin
            step_i = (i == 2);
            tick();
            check("hold_state", state_o, 5'b00100);
            check("hold_sel", sel_o, 1'b0);
        end
        check("hold_drop_ovf", ovf_o, 1'b1);
        hold_i = 1'b0; step_i = 1'b0;
        tick(); tick();
        check("hold_r2", state_o, 5'b00100);
        tick();
        check("hold_r3", state_o, 5'b01000);

        // Loop with mode 1 starting from 00001
        clr_i = 1'b1;
        tick(); tick(); tick();
        clr_i = 1'b0;
        step_i = 1'b1; nxt_i = 5'b00001;
        tick();
        step_i = 1'b0;
        tick(); tick(); tick();
        step_i = 1'b1; nxt_i = 5'b00101;
        tick();
`ifdef ONEHOT_CHECK_EN
        check("chk_state", state_o, 5'b00001);
        check("chk_err", err_o, 1'b1);
        check("chk_errcnt", err_cnt_o, 1);
`else
        check("nochk_state", state_o, 5'b00101);
        check("nochk_err", err_o, 1'b0);
`endif
        step_i = 1'b0;
        tick();
        check("err_pulse_end", err_o, 1'b0);
        tick(); tick();
        step_i = 1'b1; nxt_i = 5'b00000;
        tick();
`ifdef ONEHOT_CHECK_EN
        check("chk_zero_state", state_o, 5'b00001);
        check("chk_zero_cnt", err_cnt_o, 2);
`else
        check("nochk_zero_state", state_o, 5'b00000);
`endif
        nxt_i = 5'b00101;
        for (int i = 0; i < 16; i++) begin
            step_i = 1'b1;
            tick();
            step_i = 1'b0;
            tick(); tick(); tick();
        end
`ifdef ONEHOT_CHECK_EN
        check("chk_sat", err_cnt_o, 15);
`else
        check("nochk_cnt", err_cnt_o, 0);
`endif
        clr_i = 1'b1;
        tick();
        check("clr_errcnt", err_cnt_o, 0);
        clr_i = 1'b0;

        // Mid-cycle reset with a request pending
        step_i = 1'b1; nxt_i = 5'b00010;
        tick(); tick(); tick();
        step_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_state", state_o, 5'b00001);
        check("mid_rst_sel", sel_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_ovf", ovf_o, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_discard", state_o, 5'b00001);

        // First step after release loads; DWELL=1 loads back to back
        step_i = 1'b1; nxt_i = 5'b00010;
        tick();
        check("post_rst_load", state_o, 5'b00010);
        check("d1_load0", d1_state_o, 5'b00010);
        nxt_i = 5'b00100;
        tick();
        check("d1_load1", d1_state_o, 5'b00100);
        check("d1_busy", d1_busy_o, 1'b0);
        nxt_i = 5'b01000;
        tick();
        check("d1_load2", d1_state_o, 5'b01000);
        step_i = 1'b0; nxt_i = 5'b10000;
        tick();
        check("d1_idle", d1_state_o, 5'b01000);
        check("d1_ovf", d1_ovf_o, 1'b0);
        tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/state_seq.md
STATE_SEQ -- requirements
Module: state_seq

Interface
REQ-001 Parameter DWELL, default 4, minimum edges between two state loads; legal range 1..15.
REQ-002 Parameter ERRW, default 4, width of the error counter.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 step_i  input  1  advance request, sampled each edge.
REQ-006 hold_i  input  1  freeze: blocks loads and the dwell count.
REQ-007 mode_i  input  1  table mode request; registered to sel_o.
REQ-008 clr_i  input  1  clears ovf_o and err_cnt_o.
REQ-009 nxt_i  input  5  next-state value returned by the downstream lookup table.
REQ-010 state_o  output  5  one-hot state register, drives the table's 'in' port.
REQ-011 sel_o  output  1  registered mode, drives the table's 'sel' port.
REQ-012 busy_o  output  1  high while a request is pending or dwell has not expired.
REQ-013 ovf_o  output  1  sticky: a step was dropped.
REQ-014 err_o  output  1  one-cycle pulse: a non-one-hot nxt_i was caught (check build only).
REQ-015 err_cnt_o  output  ERRW  saturating count of caught errors.

Function
REQ-016 The block is the state register feeding the lookup table; state_o and sel_o close the loop, and nxt_i returns the table's output.
REQ-017 sel_o SHALL take mode_i on every edge where hold_i=0; hold_i=1 keeps its value.
REQ-018 Dwell counter cnt (4 bits) SHALL clear to 0 on a load, then increment each non-hold edge, saturating at DWELL-1; done = (cnt==DWELL-1).
REQ-019 A load SHALL occur on an edge where (step_i | pending) & done & !hold_i; state_o takes nxt_i on that edge (latency 1), and pending clears.
REQ-020 A step_i that does not load SHALL set pending; a step_i while pending=1 with no load SHALL be dropped and set ovf_o.
REQ-021 If step_i=1 and pending=1 on a loading edge, the pending request is consumed, pending stays 1, and nothing is dropped.
REQ-022 hold_i=1 SHALL freeze cnt, state_o and sel_o; a step_i still sets pending or ovf_o per REQ-020.
REQ-023 busy_o = pending | !done, combinational from registers.
REQ-024 clr_i SHALL clear ovf_o and err_cnt_o on the edge; a simultaneous drop or error on that edge wins (sets or increments).
REQ-025 With DWELL=1, done is always 1 and back-to-back loads occur on consecutive edges.

Reset
REQ-026 rst_n=0 SHALL immediately set state_o=5'b00001, sel_o=0, pending=0, cnt=DWELL-1 (done=1), ovf_o=0, err_o=0, err_cnt_o=0.
REQ-027 Reset during a dwell or with a request pending SHALL discard the request; the first step after release loads on its own edge.

Configuration
REQ-028 Macro ONEHOT_CHECK_EN defined: on a load where nxt_i is not exactly one-hot (including 5'b00000), state_o SHALL load 5'b00001 instead, err_o pulses for 1 cycle, and err_cnt_o increments, saturating.
REQ-029 ONEHOT_CHECK_EN undefined: nxt_i SHALL load unchecked, and err_o and err_cnt_o are tied 0.

Verification
REQ-030 Reset: assert rst_n=0 mid-cycle -> state_o=00001, sel_o=0, busy_o=0, ovf_o=0 without waiting for a clock edge.
REQ-031 Latency: DWELL=4, idle, step_i at edge k with nxt_i=01000 -> state_o=01000 after edge k, busy_o=1 until edge k+3, next load possible at edge k+4.
REQ-032 Pending and overflow: steps at edges k and k+1 during dwell, then one at k+2 -> second request pending and loads at the dwell expiry edge, third sets ovf_o=1; clr_i -> ovf_o=0.
REQ-033 Hold: hold_i=1 for 5 edges with a request pending -> state_o, cnt and sel_o unchanged; load occurs on the first done edge after release.
REQ-034 Check build, loop the real table with mode_i=1 from 00001: load with nxt_i=00101 -> state_o=00001, err_o pulse, err_cnt_o=1; 16 errors with ERRW=4 -> err_cnt_o stays 15.
REQ-035 No-check build, same stimulus -> state_o=00101, then 00000 on the next load; err_o and err_cnt_o stay 0.
